// File: rtl/centroid_div_sched_if.sv
// Start/ready handshake between the centroid scheduler (master) and the shared
// sequential unsigned divider (slave).
interface centroid_div_sched_if #(
  parameter int SUM_W = 32
);
  logic             start;
  logic [SUM_W-1:0] dividend;
  logic [SUM_W-1:0] divisor;
  logic [SUM_W-1:0] quotient;
  logic             ready;

  modport master (output start, dividend, divisor, input quotient, ready);
  modport slave  (input start, dividend, divisor, output quotient, ready);
endinterface

// File: rtl/centroid_div_sched.sv
// Time-shares one sequential divider across NUM_CH centroid accumulators:
// snapshots all sums at frame end, then divides x and y channel by channel.
module centroid_div_sched #(
  parameter int NUM_CH  = 4,
  parameter int SUM_W   = 32,
  parameter int CNT_W   = 20,
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_frame_done,
  input  logic [NUM_CH*SUM_W-1:0] i_sum_x,
  input  logic [NUM_CH*SUM_W-1:0] i_sum_y,
  input  logic [NUM_CH*CNT_W-1:0] i_count,
  centroid_div_sched_if.master    div,
  output logic [NUM_CH*X_W-1:0]   o_c_x,
  output logic [NUM_CH*Y_W-1:0]   o_c_y,
  output logic [NUM_CH-1:0]       o_ch_valid,
  output logic                    o_results_strobe,
  output logic                    o_busy,
  output logic [7:0]              o_overrun_cnt,
  output logic                    o_timeout_err
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [SUM_W-1:0] X_MAX = SUM_W'((64'd1 << X_W) - 64'd1);
  localparam logic [SUM_W-1:0] Y_MAX = SUM_W'((64'd1 << Y_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START_X, S_WAIT_X, S_START_Y, S_WAIT_Y, S_NEXT, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CH_W-1:0]         r_ch;
  logic [NUM_CH*SUM_W-1:0] r_sum_x;
  logic [NUM_CH*SUM_W-1:0] r_sum_y;
  logic [NUM_CH*CNT_W-1:0] r_count;
  logic                    r_guard;
  logic [TMR_W-1:0]        r_timer;
  logic [NUM_CH*X_W-1:0]   r_cx;
  logic [NUM_CH*Y_W-1:0]   r_cy;
  logic [NUM_CH-1:0]       r_valid;
  logic                    r_terr;
  logic [7:0]              r_overrun;

  logic [CNT_W-1:0] w_cnt;
  logic [SUM_W-1:0] w_sum_x;
  logic [SUM_W-1:0] w_sum_y;
  logic             w_last;
  logic             w_hit;
  logic             w_expired;
  logic [X_W-1:0]   w_qx;
  logic [Y_W-1:0]   w_qy;

  assign w_cnt     = r_count[int'(r_ch)*CNT_W +: CNT_W];
  assign w_sum_x   = r_sum_x[int'(r_ch)*SUM_W +: SUM_W];
  assign w_sum_y   = r_sum_y[int'(r_ch)*SUM_W +: SUM_W];
  assign w_last    = (r_ch == CH_W'(NUM_CH - 1));
  // The first wait cycle never accepts ready: the divider may still show its idle level.
  assign w_hit     = !r_guard && div.ready;
  assign w_expired = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_qx      = (div.quotient > X_MAX) ? '1 : div.quotient[X_W-1:0];
  assign w_qy      = (div.quotient > Y_MAX) ? '1 : div.quotient[Y_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_frame_done) w_next = S_CHECK;
      S_CHECK:   w_next = (w_cnt == '0) ? S_NEXT : S_START_X;
      S_START_X: w_next = S_WAIT_X;
      S_WAIT_X:  if (w_hit) w_next = S_START_Y;
                 else if (w_expired) w_next = S_NEXT;
      S_START_Y: w_next = S_WAIT_Y;
      S_WAIT_Y:  if (w_hit || w_expired) w_next = S_NEXT;
      S_NEXT:    w_next = w_last ? S_DONE : S_CHECK;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    div.start        = (r_state == S_START_X) || (r_state == S_START_Y);
    div.dividend     = ((r_state == S_START_Y) || (r_state == S_WAIT_Y)) ? w_sum_y : w_sum_x;
    div.divisor      = SUM_W'(w_cnt);
    o_busy           = (r_state != S_IDLE);
    o_results_strobe = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ch      <= '0;
      r_sum_x   <= '0;
      r_sum_y   <= '0;
      r_count   <= '0;
      r_guard   <= 1'b0;
      r_timer   <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_valid   <= '0;
      r_terr    <= 1'b0;
      r_overrun <= '0;
    end else begin
      if (i_frame_done && (r_state != S_IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
      case (r_state)
        S_IDLE: if (i_frame_done) begin
          r_sum_x <= i_sum_x;
          r_sum_y <= i_sum_y;
          r_count <= i_count;
          r_terr  <= 1'b0;
          r_ch    <= '0;
        end
        S_CHECK: if (w_cnt == '0) r_valid[r_ch] <= 1'b0;
        S_START_X, S_START_Y: begin
          r_guard <= 1'b1;
          r_timer <= '0;
        end
        S_WAIT_X: begin
          r_guard <= 1'b0;
          r_timer <= r_timer + 1'b1;
          if (w_hit) r_cx[int'(r_ch)*X_W +: X_W] <= w_qx;
          else if (w_expired) begin
            r_terr        <= 1'b1;
            r_valid[r_ch] <= 1'b0;
          end
        end
        S_WAIT_Y: begin
          r_guard <= 1'b0;
          r_timer <= r_timer + 1'b1;
          if (w_hit) begin
            r_cy[int'(r_ch)*Y_W +: Y_W] <= w_qy;
            r_valid[r_ch]               <= 1'b1;
          end else if (w_expired) begin
            r_terr        <= 1'b1;
            r_valid[r_ch] <= 1'b0;
          end
        end
        S_NEXT: if (!w_last) r_ch <= r_ch + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_c_x         = r_cx;
  assign o_c_y         = r_cy;
  assign o_ch_valid    = r_valid;
  assign o_overrun_cnt = r_overrun;
  assign o_timeout_err = r_terr;
endmodule

// File: tb/tb_centroid_div_sched.sv
// Scoreboard bench for centroid_div_sched: a behavioural centroid model predicts
// each run's results, a monitor compares them when results_strobe fires.
module tb_centroid_div_sched;
  localparam int NUM_CH  = 3;
  localparam int SUM_W   = 32;
  localparam int CNT_W   = 20;
  localparam int X_W     = 11;
  localparam int Y_W     = 10;
  localparam int TIMEOUT = 64;
  localparam int unsigned XMAX = (1 << X_W) - 1;
  localparam int unsigned YMAX = (1 << Y_W) - 1;

  typedef struct {
    logic [NUM_CH*X_W-1:0] cx;
    logic [NUM_CH*Y_W-1:0] cy;
    logic [NUM_CH-1:0]     valid;
    logic                  tErr;
    int                    starts;
    int                    startBase;
    int                    lat;
    int                    launch;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    frameDone = 1'b0;
  logic [NUM_CH*SUM_W-1:0] sumX = '0;
  logic [NUM_CH*SUM_W-1:0] sumY = '0;
  logic [NUM_CH*CNT_W-1:0] countIn = '0;
  logic [NUM_CH*X_W-1:0]   cX;
  logic [NUM_CH*Y_W-1:0]   cY;
  logic [NUM_CH-1:0]       chValid;
  logic                    strobe;
  logic                    busy;
  logic [7:0]              overrun;
  logic                    tErr;

  centroid_div_sched_if #(.SUM_W(SUM_W)) divBus();

  centroid_div_sched #(
    .NUM_CH(NUM_CH), .SUM_W(SUM_W), .CNT_W(CNT_W),
    .X_W(X_W), .Y_W(Y_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_frame_done(frameDone),
    .i_sum_x(sumX), .i_sum_y(sumY), .i_count(countIn),
    .div(divBus),
    .o_c_x(cX), .o_c_y(cY), .o_ch_valid(chValid),
    .o_results_strobe(strobe), .o_busy(busy),
    .o_overrun_cnt(overrun), .o_timeout_err(tErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  exp_t expQ[$];
  exp_t monE;

  int unsigned sx[NUM_CH];
  int unsigned sy[NUM_CH];
  int unsigned cnt[NUM_CH];
  int unsigned prevX[NUM_CH];
  int unsigned prevY[NUM_CH];
  int hangCh = -1;
  int ovTotal = 0;

  // Divider model: D cycles from start to result, optional stale ready, optional hang.
  int divD = 33;
  bit staleMode = 1'b0;
  int hangStart = -1;
  int startsTotal = 0;
  int divCnt = 0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    if (reset) begin
      divBus.ready    <= 1'b1;
      divBus.quotient <= '0;
      divCnt          <= 0;
    end else if (divBus.start) begin
      startsTotal <= startsTotal + 1;
      if (startsTotal == hangStart) begin
        divBus.ready <= 1'b0;
        divCnt       <= 0;
      end else begin
        divCnt       <= divD - 1;
        divBus.ready <= staleMode;
        if (staleMode) divBus.quotient <= 32'h15A;
      end
    end else if (divCnt > 0) begin
      divCnt <= divCnt - 1;
      if (divCnt == 1) begin
        divBus.ready    <= 1'b1;
        divBus.quotient <= divBus.dividend / divBus.divisor;
      end else begin
        divBus.ready <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (strobe) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got strobe at cycle %0d expected none", cycle);
      end else begin
        monE = expQ.pop_front();
        checkOutput("c_x", cX, monE.cx);
        checkOutput("c_y", cY, monE.cy);
        checkOutput("ch_valid", chValid, monE.valid);
        checkOutput("timeout_err", tErr, monE.tErr);
        checkOutput("busy_at_strobe", busy, 1);
        checkOutput("div_starts", startsTotal - monE.startBase, monE.starts);
        if (monE.lat >= 0) checkOutput("latency", cycle - monE.launch, monE.lat);
      end
    end
  end

  task automatic setChannel(input int c, input int unsigned x, input int unsigned y, input int unsigned n);
    sx[c]  = x;
    sy[c]  = y;
    cnt[c] = n;
  endtask

  task automatic scrambleInputs();
    for (int i = 0; i < NUM_CH; i++) begin
      sumX[i*SUM_W +: SUM_W]    = $urandom;
      sumY[i*SUM_W +: SUM_W]    = $urandom;
      countIn[i*CNT_W +: CNT_W] = CNT_W'($urandom);
    end
  endtask

  // Predict the run, launch it, then optionally fire ignored frame_done pulses.
  task automatic applyStimulus(input int ovWanted, output int ovDone);
    exp_t e;
    int hangLocal = -1;
    int lat = 1;
    bit latKnown = 1'b1;
    int unsigned qx, qy;
    e.starts = 0;
    e.valid  = '0;
    e.tErr   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt[c] == 0) begin
        lat += 2;
      end else if (c == hangCh) begin
        e.tErr    = 1'b1;
        hangLocal = e.starts;
        e.starts += 1;
        latKnown  = 1'b0;
      end else begin
        qx = sx[c] / cnt[c];
        qy = sy[c] / cnt[c];
        prevX[c]   = (qx > XMAX) ? XMAX : qx;
        prevY[c]   = (qy > YMAX) ? YMAX : qy;
        e.valid[c] = 1'b1;
        e.starts  += 2;
        lat       += 4 + 2 * divD;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e.cx[c*X_W +: X_W] = X_W'(prevX[c]);
      e.cy[c*Y_W +: Y_W] = Y_W'(prevY[c]);
    end
    e.lat  = latKnown ? lat : -1;
    ovDone = latKnown ? ((ovWanted < lat) ? ovWanted : lat) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      sumX[i*SUM_W +: SUM_W]    = sx[i];
      sumY[i*SUM_W +: SUM_W]    = sy[i];
      countIn[i*CNT_W +: CNT_W] = CNT_W'(cnt[i]);
    end
    @(posedge clk); #1;
    hangStart   = (hangLocal >= 0) ? startsTotal + hangLocal : -1;
    e.startBase = startsTotal;
    e.launch    = cycle;
    expQ.push_back(e);
    frameDone = 1'b1;
    @(posedge clk); #1;
    frameDone = (ovDone >= 1);
    scrambleInputs();
    for (int k = 2; k <= ovDone; k++) begin
      @(posedge clk); #1;
      frameDone = 1'b1;
      scrambleInputs();
    end
    @(posedge clk); #1;
    frameDone = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (expQ.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout: got no strobe after %0d cycles expected one", n);
      expQ.delete();
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_strobe"}, strobe, 0);
    checkOutput({tag, "_c_x"}, cX, 0);
    checkOutput({tag, "_c_y"}, cY, 0);
    checkOutput({tag, "_ch_valid"}, chValid, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
    checkOutput({tag, "_timeout_err"}, tErr, 0);
    checkOutput({tag, "_div_start"}, divBus.start, 0);
    checkOutput({tag, "_dividend"}, divBus.dividend, 0);
    checkOutput({tag, "_divisor"}, divBus.divisor, 0);
  endtask

  initial begin
    int pulsed;
    int r;
    for (int c = 0; c < NUM_CH; c++) begin
      prevX[c] = 0;
      prevY[c] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    reset = 1'b0;

    $display("[TB] nominal divisions");
    setChannel(0, 50000, 30000, 100);
    setChannel(1, 9900, 19800, 99);
    setChannel(2, 70000, 7000, 1000);
    applyStimulus(0, pulsed);
    waitDone();

    $display("[TB] zero-count channel skipped");
    setChannel(0, 12345, 6789, 50);
    setChannel(1, 99999, 99999, 0);
    setChannel(2, 4000, 800, 40);
    applyStimulus(0, pulsed);
    waitDone();

    $display("[TB] saturation boundaries");
    setChannel(0, 30000, 15000, 10);
    setChannel(1, 10235, 5120, 5);
    setChannel(2, 2046 * 3 + 2, 1022 * 3, 3);
    applyStimulus(0, pulsed);
    waitDone();

    $display("[TB] overrun counting");
    setChannel(1, 9900, 19800, 99);
    applyStimulus(3, pulsed);
    waitDone();
    ovTotal += pulsed;
    checkOutput("overrun_3", overrun, 3);
    while (ovTotal < 300) begin
      applyStimulus(300 - ovTotal, pulsed);
      waitDone();
      ovTotal += pulsed;
      checkOutput("overrun_cnt", overrun, (ovTotal > 255) ? 255 : ovTotal);
    end

    $display("[TB] divider timeout on channel 0");
    setChannel(0, 77777, 55555, 77);
    hangCh = 0;
    applyStimulus(0, pulsed);
    waitDone();
    hangCh = -1;

    $display("[TB] stale ready level");
    staleMode = 1'b1;
    setChannel(0, 123456, 65432, 321);
    setChannel(1, 200000, 100000, 1000);
    setChannel(2, 5000, 2500, 25);
    applyStimulus(0, pulsed);
    waitDone();
    staleMode = 1'b0;

    $display("[TB] reset during WAIT_Y");
    setChannel(0, 64000, 32000, 64);
    applyStimulus(0, pulsed);
    repeat (divD + 3) @(posedge clk);
    #1;
    checkOutput("c_x0_before_reset", cX[X_W-1:0], prevX[0]);
    reset = 1'b1;
    @(posedge clk); #1;
    checkReset("reset_mid_run");
    reset = 1'b0;
    expQ.delete();
    ovTotal = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      prevX[c] = 0;
      prevY[c] = 0;
    end
    repeat (300) @(posedge clk);

    $display("[TB] randomized frames");
    for (int f = 0; f < 25; f++) begin
      divD      = $urandom_range(3, 10);
      staleMode = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          setChannel(c, $urandom, $urandom, 0);
        end else if (r == 1) begin
          setChannel(c, $urandom, $urandom, $urandom_range(1, (1 << CNT_W) - 1));
        end else begin
          cnt[c] = $urandom_range(1, 4000);
          sx[c]  = $urandom_range(0, 2300) * cnt[c] + $urandom_range(0, cnt[c] - 1);
          sy[c]  = $urandom_range(0, 1200) * cnt[c] + $urandom_range(0, cnt[c] - 1);
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        hangCh = $urandom_range(0, NUM_CH - 1);
        if (cnt[hangCh] == 0) cnt[hangCh] = 7;
      end else begin
        hangCh = -1;
      end
      applyStimulus($urandom_range(0, 2), pulsed);
      waitDone();
      ovTotal += pulsed;
      checkOutput("overrun_random", overrun, (ovTotal > 255) ? 255 : ovTotal);
    end
    hangCh = -1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/centroid_div_sched.md
Name: centroid_div_sched

Overview:
Shares one sequential unsigned divider between NUM_CH colour-channel centroid accumulators. At end of frame it snapshots every channel's sum_x, sum_y and white_count. It then runs the divisions sum_x/count and sum_y/count channel by channel and publishes a registered centroid per channel. It sits between the per-channel accumulators and the downstream tracking/overlay logic, replacing the two-dividers-per-channel arrangement.

Parameters:
NUM_CH, 4, number of channels sharing the divider (1..8)
SUM_W, 32, width of each sum input and the divider dividend
CNT_W, 20, width of each count input; zero-extended to SUM_W for the divisor
X_W, 11, width of each c_x output
Y_W, 10, width of each c_y output
TIMEOUT, 64, cycles allowed in a WAIT state before the division is aborted

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
frame_done  in  1  one-cycle pulse; accumulator inputs are stable in this cycle
sum_x_in  in  NUM_CH*SUM_W  packed x sums, channel 0 in the LSBs
sum_y_in  in  NUM_CH*SUM_W  packed y sums
count_in  in  NUM_CH*CNT_W  packed white counts
div_start  out  1  one-cycle start pulse to the shared divider
div_dividend  out  SUM_W  dividend presented to the divider
div_divisor  out  SUM_W  divisor presented to the divider
div_quotient  in  SUM_W  divider quotient
div_ready  in  1  divider ready (level; falls after start, rises when the result is valid)
c_x  out  NUM_CH*X_W  packed centroid x
c_y  out  NUM_CH*Y_W  packed centroid y
ch_valid  out  NUM_CH  channel's centroid came from a successful division this frame
results_strobe  out  1  one-cycle pulse when all channels have been updated
busy  out  1  high in any state other than IDLE
overrun_cnt  out  8  saturating count of frame_done pulses ignored while busy
timeout_err  out  1  a division timed out during the current run

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - snapshot registers 0.
  - Reset mid-run aborts immediately: no strobe, and c_x/c_y clear to 0.
- IDLE:
  - frame_done=1 copies all inputs into the snapshot, clears timeout_err, sets ch=0, and moves to CHECK on the next cycle.
  - Without frame_done, IDLE holds.
- CHECK:
  - If count[ch]==0, the division is skipped: c_x/c_y for ch hold their previous values, ch_valid[ch]<=0, go to NEXT.
  - Otherwise go to START_X.
- START_X:
  - div_start=1 for exactly one cycle.
  - div_dividend = snapshot sum_x[ch]; div_divisor = count[ch] zero-extended.
  - Go to WAIT_X with guard=1 and timer=0.
- WAIT_X:
  - In the first cycle (guard), div_ready is ignored so that a stale ready level is not taken as the result.
  - After the guard cycle, div_ready==1 latches the quotient into c_x[ch] and goes to START_Y.
  - Saturation: if quotient > 2^X_W-1, c_x[ch] = all ones.
  - Timeout: if timer reaches TIMEOUT, set timeout_err=1, set ch_valid[ch]=0, and go to NEXT; channel ch keeps its old c_x/c_y.
- START_Y / WAIT_Y:
  - Identical to START_X / WAIT_X, using sum_y and c_y (saturate at 2^Y_W-1).
  - On success, ch_valid[ch]<=1, then go to NEXT.
- div_dividend/div_divisor stay stable from the start cycle until the matching WAIT state exits.
- NEXT:
  - If ch==NUM_CH-1, go to DONE.
  - Otherwise ch<=ch+1 and go to CHECK.
- DONE: results_strobe=1 for one cycle, then IDLE.
  - c_x, c_y and ch_valid are not guaranteed coherent until the strobe.
  - On the strobe, all channels reflect the snapshot's frame.
- Overrun:
  - frame_done while busy (including the DONE cycle) is ignored and overrun_cnt increments, saturating at 255.
  - The run in progress continues unaffected.
- Latency: with an ideal D-cycle divider, a full run takes 2 + NUM_CH*(4+2D) cycles from frame_done to the strobe.
  - Each skipped channel costs 2 cycles.

Test Plan:
1. NUM_CH=2, ch0 sums (x=50000, y=30000, count=100), ch1 (x=9900, y=19800, count=99); divider model D=33 -> strobe once; c_x0=500, c_y0=300, c_x1=100, c_y1=200; ch_valid=2'b11; div_start pulses exactly 4 times.
2. ch1 count=0 -> ch1 keeps its previous c_x/c_y; ch_valid[1]=0; only 2 div_start pulses; strobe still fires.
3. x quotient 3000 with X_W=11 -> c_x=2047; y quotient 1500 with Y_W=10 -> c_y=1023.
4. frame_done pulsed 3 times mid-run -> overrun_cnt=3; results match the first snapshot; no second run starts. After 300 ignored pulses, overrun_cnt=255.
5. Divider model never raises ready on ch0 x -> after TIMEOUT=64 cycles timeout_err=1 and ch_valid[0]=0; ch1 completes normally; strobe fires.
6. Divider holds ready=1 through the start cycle -> the guard ignores it and the true result is latched. Reset asserted in WAIT_Y -> next cycle busy=0, all outputs 0, no strobe.
